// File: rtl/tx_ffe_ser_if.sv
// Parallel-word handshake between a word source and the tx_ffe_ser serializer.
//   in_data  : parallel word; bit 0 is transmitted first
//   in_valid : source has a word
//   in_ready : serializer takes the word on an edge where in_valid && in_ready
// Modports: master = word source, slave = serializer.
interface tx_ffe_ser_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tx_ffe_ser.sv
// Transmit serializer with a 3-tap FIR driver.
// Words arrive over tx_ffe_ser_if and are sent LSB-first, one symbol per clk
// (bit 1 -> +1, bit 0 -> -1, idle -> 0). The drive level is the saturated sum
// pre*w_next + main*w_cur + post*w_prev, using shadow-loaded taps.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : in_data / in_valid / in_ready word handshake
//   tap_pre/main/post : signed taps, copied into shadow registers on tap_load
//   tap_load          : 1-cycle strobe to update the shadow taps
//   out               : signed registered drive level
//   active            : serializer holds a word
//   underrun          : 1-cycle pulse when the stream goes idle
// Optional: define TX_PRBS_EN to add input prbs_mode, which replaces the data
// stream with a PRBS7 pattern (x^7+x^6+1, seed 7'h7F) while high.
module tx_ffe_ser #(
  parameter int WORD_WIDTH = 8,
  parameter int TAP_WIDTH  = 8,
  parameter int OUT_WIDTH  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  tx_ffe_ser_if.slave                 bus,
  input  logic signed [TAP_WIDTH-1:0] tap_pre,
  input  logic signed [TAP_WIDTH-1:0] tap_main,
  input  logic signed [TAP_WIDTH-1:0] tap_post,
  input  logic                        tap_load,
`ifdef TX_PRBS_EN
  input  logic                        prbs_mode,
`endif
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        active,
  output logic                        underrun
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam int SUM_W = TAP_WIDTH + 2;
  localparam int EXT_W = (SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_WIDTH - 1);
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  localparam logic signed [1:0] SYM_P = 2'sb01;
  localparam logic signed [1:0] SYM_M = 2'sb11;
  localparam logic signed [1:0] SYM_Z = 2'sb00;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                        state;
  logic [WORD_WIDTH-1:0]         shreg;
  logic [CNT_W-1:0]              cnt;
  logic signed [1:0]             w_next, w_cur, w_prev;
  logic signed [TAP_WIDTH-1:0]   sh_pre, sh_main, sh_post;
  logic signed [SUM_W-1:0]       sum_full;
  logic signed [EXT_W-1:0]       sum_ext;
  logic signed [OUT_WIDTH-1:0]   sat_val;
  logic                          prbs_on;
`ifdef TX_PRBS_EN
  logic [6:0]                    lfsr;
  assign prbs_on = prbs_mode;
`else
  assign prbs_on = 1'b0;
`endif

  function automatic logic signed [SUM_W-1:0] term(input logic signed [1:0] w,
                                                   input logic signed [TAP_WIDTH-1:0] t);
    logic signed [SUM_W-1:0] te;
    te = SUM_W'(t);
    case (w)
      SYM_P:   term = te;
      SYM_M:   term = -te;
      default: term = '0;
    endcase
  endfunction

  assign bus.in_ready = ((state == ST_IDLE) || (cnt == LAST)) && !prbs_on;
  assign active       = (state == ST_BUSY) || prbs_on;

  always_comb begin
    sum_full = term(w_next, sh_pre) + term(w_cur, sh_main) + term(w_prev, sh_post);
    sum_ext  = EXT_W'(sum_full);
    sat_val  = sum_ext[OUT_WIDTH-1:0];
    if (sum_ext > OUT_MAX)      sat_val = OUT_MAX[OUT_WIDTH-1:0];
    else if (sum_ext < OUT_MIN) sat_val = OUT_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      w_next   <= SYM_Z;
      w_cur    <= SYM_Z;
      w_prev   <= SYM_Z;
      sh_pre   <= '0;
      sh_main  <= '0;
      sh_post  <= '0;
      out      <= '0;
      underrun <= 1'b0;
`ifdef TX_PRBS_EN
      lfsr     <= 7'h7F;
`endif
    end else begin
      // out is built from the window and taps as they stood before this edge
      out      <= sat_val;
      w_prev   <= w_cur;
      w_cur    <= w_next;
      underrun <= 1'b0;
      if (tap_load) begin
        sh_pre  <= tap_pre;
        sh_main <= tap_main;
        sh_post <= tap_post;
      end
`ifdef TX_PRBS_EN
      if (prbs_mode) begin
        // Pattern replaces the data path; any word in flight is abandoned
        w_next <= lfsr[6] ? SYM_P : SYM_M;
        lfsr   <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        state  <= ST_IDLE;
        cnt    <= '0;
      end else
`endif
      begin
        w_next <= (state == ST_BUSY) ? (shreg[0] ? SYM_P : SYM_M) : SYM_Z;
        case (state)
          ST_IDLE: begin
            if (bus.in_valid) begin
              shreg <= bus.in_data;
              cnt   <= '0;
              state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (cnt != LAST) begin
              shreg <= shreg >> 1;
              cnt   <= cnt + 1'b1;
            end else if (bus.in_valid) begin
              shreg <= bus.in_data;
              cnt   <= '0;
            end else begin
              state    <= ST_IDLE;
              underrun <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_ffe_ser.sv
module tb_tx_ffe_ser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default build: OUT_WIDTH = 10
  tx_ffe_ser_if #(.WORD_WIDTH(8)) bus1 ();
  logic signed [7:0] pre1 = '0, main1 = '0, post1 = '0;
  logic              load1 = 1'b0;
  logic signed [9:0] out1;
  logic              active1, underrun1;

  // Narrow output for saturation: OUT_WIDTH = 8
  tx_ffe_ser_if #(.WORD_WIDTH(8)) bus2 ();
  logic signed [7:0] pre2 = '0, main2 = '0, post2 = '0;
  logic              load2 = 1'b0;
  logic signed [7:0] out2;
  logic              active2, underrun2;

`ifdef TX_PRBS_EN
  logic prbs1 = 1'b0;
  logic prbs2 = 1'b0;
`endif

  tx_ffe_ser #(.WORD_WIDTH(8), .TAP_WIDTH(8), .OUT_WIDTH(10)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .tap_pre(pre1), .tap_main(main1), .tap_post(post1), .tap_load(load1),
`ifdef TX_PRBS_EN
    .prbs_mode(prbs1),
`endif
    .out(out1), .active(active1), .underrun(underrun1)
  );

  tx_ffe_ser #(.WORD_WIDTH(8), .TAP_WIDTH(8), .OUT_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .tap_pre(pre2), .tap_main(main2), .tap_post(post2), .tap_load(load2),
`ifdef TX_PRBS_EN
    .prbs_mode(prbs2),
`endif
    .out(out2), .active(active2), .underrun(underrun2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_taps1(input int p, input int m, input int q);
    pre1 = 8'(p); main1 = 8'(m); post1 = 8'(q); load1 = 1'b1;
    tick();
    load1 = 1'b0;
  endtask

  int exp_single [12] = '{0, -16, 112, -104, -56, -56, -56, -56, -56, -72, 24, 0};
  logic [23:0] stream;

  initial begin
    bus1.in_data = '0; bus1.in_valid = 1'b0;
    bus2.in_data = '0; bus2.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out1, 0);
    check("rst_ready", int'(bus1.in_ready), 1);
    check("rst_active", int'(active1), 0);
    check("rst_underrun", int'(underrun1), 0);
    check("rst_out2", out2, 0);
    rst = 1'b0;
    tick();

    // Single word 8'h01 from idle with pre=-16 main=96 post=-24
    load_taps1(-16, 96, -24);
    bus1.in_data = 8'h01; bus1.in_valid = 1'b1;
    tick();                              // E0
    bus1.in_valid = 1'b0; bus1.in_data = 8'hEE;
    check("single_ready_e0", int'(bus1.in_ready), 0);
    check("single_active_e0", int'(active1), 1);
    for (int i = 0; i < 12; i++) begin
      tick();                            // E(i+1)
      check($sformatf("single_out_e%0d", i + 1), out1, exp_single[i]);
      if (i == 6) check("single_ready_last", int'(bus1.in_ready), 1);
      if (i == 7) begin
        check("single_underrun", int'(underrun1), 1);
        check("single_active_end", int'(active1), 0);
      end
      if (i == 8) check("single_underrun_clr", int'(underrun1), 0);
    end

    // Back-to-back A5, 3C, FF with main-only taps: out after En = bit(n-3)
    load_taps1(0, 100, 0);
    stream = {8'hFF, 8'h3C, 8'hA5};
    bus1.in_data = 8'hA5; bus1.in_valid = 1'b1;
    for (int k = 0; k < 28; k++) begin
      tick();                            // Ek
      if (k < 24) begin
        check($sformatf("b2b_ready_e%0d", k), int'(bus1.in_ready), (k % 8 == 7) ? 1 : 0);
        check($sformatf("b2b_active_e%0d", k), int'(active1), 1);
      end
      check($sformatf("b2b_underrun_e%0d", k), int'(underrun1), (k == 24) ? 1 : 0);
      if (k >= 3 && k <= 26)
        check($sformatf("b2b_out_e%0d", k), out1, stream[k-3] ? 100 : -100);
      if (k == 27) check("b2b_out_idle", out1, 0);
      if (k == 0)  bus1.in_data = 8'h3C;
      if (k == 8)  bus1.in_data = 8'hFF;
      if (k == 16) bus1.in_valid = 1'b0;
    end

    // Tap update mid-word: main 32 -> 64 loaded at E5
    load_taps1(0, 32, 0);
    bus1.in_data = 8'hFF; bus1.in_valid = 1'b1;
    tick();                              // E0
    bus1.in_valid = 1'b0;
    repeat (4) tick();                   // E4
    check("tap_old_e4", out1, 32);
    main1 = 8'sd64; load1 = 1'b1;
    tick();                              // E5: load edge, old taps
    load1 = 1'b0;
    check("tap_load_edge", out1, 32);
    tick();                              // E6: new taps
    check("tap_new", out1, 64);
    repeat (8) tick();
    check("tap_drain", out1, 0);

    // Async reset mid-word
    bus1.in_data = 8'hFF; bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    repeat (4) tick();
    check("mid_pre_rst", out1, 64);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", out1, 0);
    check("mid_rst_ready", int'(bus1.in_ready), 1);
    check("mid_rst_active", int'(active1), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_rst_underrun_%0d", i), int'(underrun1), 0);
    end
    check("post_rst_out", out1, 0);

    // Saturation on the 8-bit output instance
    pre2 = 8'sd127; main2 = 8'sd127; post2 = 8'sd127; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    bus2.in_data = 8'hFF; bus2.in_valid = 1'b1;
    tick();                              // E0
    repeat (2) tick();                   // E2
    check("sat_e2", out2, 127);
    tick();                              // E3: 254
    check("sat_e3", out2, 127);
    tick();                              // E4: 381
    check("sat_e4_pos", out2, 127);
    pre2 = 8'h80; main2 = 8'h80; post2 = 8'h80; load2 = 1'b1;
    tick();                              // E5: old taps
    load2 = 1'b0;
    check("sat_e5_old", out2, 127);
    bus2.in_valid = 1'b0;
    tick();                              // E6: -384
    check("sat_e6_neg", out2, -128);
    repeat (10) tick();
    check("sat_drain", out2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
